apb_sram_slave: RTL and testbench

- APB completer memory sitting directly downstream of the AHB-to-APB bridge.
- Consumes the bridge's psel/penable/pprot/paddr/pwrite/pstrb/pwdata and returns prdata/pslverr/pready.
- Provides word-addressed SRAM storage with byte strobes, programmable wait states, and error responses for bad address, misalignment and secure-region violations.
- Used as the bridge's default downstream target in block and subsystem benches.

---
 rtl/ahb2apb_verif_param_pkg.sv | 7 +
 rtl/apb_names_pkg.sv | 17 +
 rtl/apb_sram_slave_if.sv | 30 +++
 rtl/apb_sram_bytelane.sv | 28 ++
 rtl/apb_sram_slave.sv | 133 +++++++++++++
 tb/tb_apb_sram_slave.sv | 245 ++++++++++++++++++++++++
 6 files changed

// File: rtl/ahb2apb_verif_param_pkg.sv
// Bus width parameters shared by the AHB-to-APB bridge and its downstream targets.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ahb2apb_verif_param_pkg;
    localparam int PADDR = 32;  // APB byte-address width
    localparam int PDATA = 32;  // APB data width (8, 16 or 32)
endpackage

// File: rtl/apb_names_pkg.sv
// Shared APB names: completer FSM states, pslverr encodings, pprot bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_names_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic PSLVERR_OKAY  = 1'b0;
    localparam logic PSLVERR_ERROR = 1'b1;

    localparam int PPROT_PRIV  = 0;  // 1 = privileged
    localparam int PPROT_NSEC  = 1;  // 1 = non-secure
    localparam int PPROT_INSTR = 2;  // 1 = instruction fetch
endpackage

// File: rtl/apb_sram_slave_if.sv
// APB requester/completer signal bundle between the bridge and a completer.
// Latency: n/a (wires only).
// Backpressure: completer stalls the requester by holding pready low.
// Ports: psel/penable/pprot/paddr/pwrite/pstrb/pwdata from requester;
//        prdata/pslverr/pready from completer.
interface apb_sram_slave_if #(
    parameter int PADDR = ahb2apb_verif_param_pkg::PADDR,
    parameter int PDATA = ahb2apb_verif_param_pkg::PDATA
);
    logic               psel;
    logic               penable;
    logic [2:0]         pprot;
    logic [PADDR-1:0]   paddr;
    logic               pwrite;
    logic [PDATA/8-1:0] pstrb;
    logic [PDATA-1:0]   pwdata;
    logic [PDATA-1:0]   prdata;
    logic               pslverr;
    logic               pready;

    modport master (
        output psel, penable, pprot, paddr, pwrite, pstrb, pwdata,
        input  prdata, pslverr, pready
    );

    modport slave (
        input  psel, penable, pprot, paddr, pwrite, pstrb, pwdata,
        output prdata, pslverr, pready
    );
endinterface

// File: rtl/apb_sram_bytelane.sv
// DEPTH x PDATA storage array with per-byte write enables; no control logic.
// Latency: write commits at the clk edge; read port is combinational.
// Backpressure: none, accepts a write every cycle.
// Ports: clk; we (one bit per byte lane); addr (word index); wdata; rdata.
module apb_sram_bytelane #(
    parameter int PDATA = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic [PDATA/8-1:0] we,
    input  logic [AW-1:0]      addr,
    input  logic [PDATA-1:0]   wdata,
    output logic [PDATA-1:0]   rdata
);
    // Deliberately not reset: contents stay undefined until written.
    logic [PDATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < PDATA/8; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/apb_sram_slave.sv
// APB completer SRAM with byte strobes, fixed wait states and pslverr on bad accesses.
// Latency: setup + (WAIT_STATES + 1) access cycles; 2 cycles when WAIT_STATES = 0.
// Backpressure: pready held low for WAIT_STATES access cycles; psel drop aborts.
// Ports: clk, reset (sync, active-high); bus = APB completer side (apb_sram_slave_if.slave).
module apb_sram_slave
    import apb_names_pkg::*;
#(
    parameter int PADDR        = ahb2apb_verif_param_pkg::PADDR,
    parameter int PDATA        = ahb2apb_verif_param_pkg::PDATA,  // 8, 16 or 32
    parameter int DEPTH        = 256,
    parameter int WAIT_STATES  = 0,                               // 0..15
    parameter int SECURE_WORDS = 16
) (
    input  logic          clk,
    input  logic          reset,
    apb_sram_slave_if.slave bus
);
    localparam int NBYTES = PDATA / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e         state_q, state_d, phase;
    logic [3:0]         cnt_q, cnt_d;
    logic               latch;
    logic [PADDR-1:0]   addr_q;
    logic               write_q;
    logic               nsec_q;
    logic [NBYTES-1:0]  strb_q;
    logic [PDATA-1:0]   wdata_q;

    logic [PADDR-1:0]   idx;
    logic               misaligned, out_of_range, sec_viol, err, done;
    logic [NBYTES-1:0]  we;
    logic [PDATA-1:0]   rdata;
    logic               unused_prot;

    // Only the secure/non-secure bit affects decode.
    assign unused_prot = bus.pprot[PPROT_PRIV] ^ bus.pprot[PPROT_INSTR];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            nsec_q  <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                addr_q  <= bus.paddr;
                write_q <= bus.pwrite;
                nsec_q  <= bus.pprot[PPROT_NSEC];
                strb_q  <= bus.pstrb;
                wdata_q <= bus.pwdata;
            end
        end
    end

    // The SETUP phase is the bus setup cycle itself, so it is recognised from
    // the idle register plus psel & !penable; capturing at the end of that
    // cycle lets a zero-wait transfer complete in its first access cycle.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && bus.psel && !bus.penable) begin
            phase = SETUP;
        end
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        case (phase)
            IDLE: begin
                state_d = IDLE;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_STATES);
                latch   = 1'b1;
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_d = IDLE;      // aborted by requester
                    cnt_d   = '0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;      // completes this cycle
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Completion needs psel still high so an abort never reports pready.
    assign done = (state_q == ACCESS) && (cnt_q == 4'd0) && bus.psel;

    assign idx = addr_q >> LSB;

    generate
        if (LSB > 0) begin : g_align
            assign misaligned = |addr_q[LSB > 0 ? LSB-1 : 0 : 0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    assign out_of_range = idx >= PADDR'(DEPTH);
    assign sec_viol     = nsec_q && (idx < PADDR'(SECURE_WORDS));
    assign err          = misaligned || out_of_range || sec_viol;

    // Reset beats a coincident completion: the write is dropped.
    assign we = (done && write_q && !err && !reset) ? strb_q : '0;

    apb_sram_bytelane #(
        .PDATA (PDATA),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (idx[AW-1:0]),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign bus.pready  = done;
    assign bus.pslverr = (done && err) ? PSLVERR_ERROR : PSLVERR_OKAY;
    assign bus.prdata  = (done && !write_q && !err) ? rdata : '0;
endmodule

// File: tb/tb_apb_sram_slave.sv
// Directed bench for apb_sram_slave: one zero-wait and one three-wait instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_sram_slave;
    import apb_names_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apb_sram_slave_if #(.PADDR(32), .PDATA(32)) b0 ();
    apb_sram_slave_if #(.PADDR(32), .PDATA(32)) b3 ();

    apb_sram_slave #(.DEPTH(256), .WAIT_STATES(0), .SECURE_WORDS(16)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    apb_sram_slave #(.DEPTH(256), .WAIT_STATES(3), .SECURE_WORDS(16)) dut3 (
        .clk(clk), .reset(reset), .bus(b3.slave));

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rd;
    logic        er;
    int          cy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Setup + access on b0; address/data are scrambled during access to show
    // that only the setup-phase values matter. Ends at the completion negedge.
    task automatic xfer0(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p,
                         output logic [31:0] rdat, output logic err, output int cyc);
        @(posedge clk); #1;
        b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = w; b0.paddr = a;
        b0.pwdata = d; b0.pstrb = s; b0.pprot = p;
        @(posedge clk); #1;
        b0.penable = 1'b1; b0.paddr = a ^ 32'h8; b0.pwdata = ~d;
        cyc = 0; rdat = 'x; err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b0.pready) begin
                cyc = k; rdat = b0.prdata; err = b0.pslverr;
                break;
            end
        end
    endtask

    task automatic idle0();
        @(posedge clk); #1;
        b0.psel = 1'b0; b0.penable = 1'b0;
    endtask

    // Same on b3, also checking that wait cycles return zero data and no error.
    task automatic xfer3(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p,
                         output logic [31:0] rdat, output logic err, output int cyc);
        @(posedge clk); #1;
        b3.psel = 1'b1; b3.penable = 1'b0; b3.pwrite = w; b3.paddr = a;
        b3.pwdata = d; b3.pstrb = s; b3.pprot = p;
        @(posedge clk); #1;
        b3.penable = 1'b1;
        cyc = 0; rdat = 'x; err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b3.pready) begin
                cyc = k; rdat = b3.prdata; err = b3.pslverr;
                break;
            end
            check("wait_prdata", b3.prdata, 32'h0);
            check("wait_pslverr", 32'(b3.pslverr), 32'h0);
        end
        @(posedge clk); #1;
        b3.psel = 1'b0; b3.penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b0.psel = 0; b0.penable = 0; b0.pwrite = 0; b0.paddr = 0;
        b0.pwdata = 0; b0.pstrb = 0; b0.pprot = 0;
        b3.psel = 0; b3.penable = 0; b3.pwrite = 0; b3.paddr = 0;
        b3.pwdata = 0; b3.pstrb = 0; b3.pprot = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_pready", 32'(b0.pready), 32'h0);
        check("rst_pslverr", 32'(b0.pslverr), 32'h0);
        check("rst_prdata", b0.prdata, 32'h0);
        check("rst_state", 32'(dut0.state_q), 32'(IDLE));

        // penable without a setup phase is ignored
        @(posedge clk); #1 b0.psel = 1'b1; b0.penable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_penable_pready", 32'(b0.pready), 32'h0);
        end
        idle0();

        // Zero-wait write then read
        xfer0(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 3'b010, rd, er, cy);
        check("wr40_cycles", 32'(cy), 32'd1);
        check("wr40_err", 32'(er), 32'h0);
        idle0();
        xfer0(1'b0, 32'h40, 32'h0, 4'h0, 3'b010, rd, er, cy);
        check("rd40_data", rd, 32'hDEADBEEF);
        check("rd40_cycles", 32'(cy), 32'd1);
        idle0();
        @(negedge clk);
        check("rd40_after_prdata", b0.prdata, 32'h0);

        // Partial strobe write
        xfer0(1'b1, 32'h40, 32'h11223344, 4'b0101, 3'b010, rd, er, cy);
        check("part_err", 32'(er), 32'h0);
        idle0();
        xfer0(1'b0, 32'h40, 32'h0, 4'h0, 3'b010, rd, er, cy);
        check("part_data", rd, 32'hDE22BE44);
        idle0();

        // Error responses
        xfer0(1'b1, 32'h42, 32'h0, 4'hF, 3'b000, rd, er, cy);
        check("mis_wr_err", 32'(er), 32'h1);
        idle0();
        xfer0(1'b0, 32'h402, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("mis402_err", 32'(er), 32'h1);
        check("mis402_data", rd, 32'h0);
        idle0();
        xfer0(1'b1, 32'h400, 32'h55555555, 4'hF, 3'b000, rd, er, cy);
        check("oor_wr_err", 32'(er), 32'h1);
        idle0();
        xfer0(1'b0, 32'h400, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("oor_rd_err", 32'(er), 32'h1);
        check("oor_rd_data", rd, 32'h0);
        idle0();
        xfer0(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("after_err_data", rd, 32'hDE22BE44);
        idle0();

        // Secure region
        xfer0(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, cy);
        check("sec_wr_err", 32'(er), 32'h0);
        idle0();
        xfer0(1'b1, 32'h0, 32'h12345678, 4'hF, 3'b010, rd, er, cy);
        check("nsec_wr_err", 32'(er), 32'h1);
        idle0();
        xfer0(1'b0, 32'h3C, 32'h0, 4'h0, 3'b010, rd, er, cy);
        check("nsec_rd3c_err", 32'(er), 32'h1);
        idle0();
        xfer0(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("sec_rd_data", rd, 32'hCAFEF00D);
        check("sec_rd_err", 32'(er), 32'h0);
        idle0();

        // Back-to-back write then read with psel held high
        xfer0(1'b1, 32'h10, 32'hA5A50F0F, 4'hF, 3'b000, rd, er, cy);
        check("b2b_wr_err", 32'(er), 32'h0);
        xfer0(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("b2b_rd_data", rd, 32'hA5A50F0F);
        check("b2b_rd_cycles", 32'(cy), 32'd1);
        idle0();

        // psel dropped in the would-be completion cycle: no pready, no write
        @(posedge clk); #1;
        b0.psel = 1; b0.penable = 0; b0.pwrite = 1; b0.paddr = 32'h40;
        b0.pwdata = 32'h0; b0.pstrb = 4'hF; b0.pprot = 3'b000;
        @(posedge clk); #1 b0.psel = 0; b0.penable = 1;
        @(negedge clk);
        check("abort0_pready", 32'(b0.pready), 32'h0);
        idle0();
        xfer0(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("abort0_data", rd, 32'hDE22BE44);
        idle0();

        // Reset coincident with completion: reset wins
        @(posedge clk); #1;
        b0.psel = 1; b0.penable = 0; b0.pwrite = 1; b0.paddr = 32'h40;
        b0.pwdata = 32'hFFFFFFFF; b0.pstrb = 4'hF; b0.pprot = 3'b000;
        @(posedge clk); #1 b0.penable = 1; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; b0.psel = 0; b0.penable = 0;
        @(negedge clk);
        check("rstc_pready", 32'(b0.pready), 32'h0);
        check("rstc_state", 32'(dut0.state_q), 32'(IDLE));
        xfer0(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("rstc_data", rd, 32'hDE22BE44);
        idle0();

        // Three wait states
        xfer3(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 3'b010, rd, er, cy);
        check("w3_wr_cycles", 32'(cy), 32'd4);
        check("w3_wr_err", 32'(er), 32'h0);
        xfer3(1'b0, 32'h40, 32'h0, 4'h0, 3'b010, rd, er, cy);
        check("w3_rd_cycles", 32'(cy), 32'd4);
        check("w3_rd_data", rd, 32'hDEADBEEF);
        @(negedge clk);
        check("w3_after_prdata", b3.prdata, 32'h0);

        // Abort mid-ACCESS on a write to 0x20
        xfer3(1'b1, 32'h20, 32'hAAAA5555, 4'hF, 3'b000, rd, er, cy);
        check("w3_pre20_err", 32'(er), 32'h0);
        @(posedge clk); #1;
        b3.psel = 1; b3.penable = 0; b3.pwrite = 1; b3.paddr = 32'h20;
        b3.pwdata = 32'h12345678; b3.pstrb = 4'hF; b3.pprot = 3'b000;
        @(posedge clk); #1 b3.penable = 1;
        @(negedge clk);
        check("abort3_wait_pready", 32'(b3.pready), 32'h0);
        @(posedge clk); #1 b3.psel = 0; b3.penable = 0;
        @(negedge clk);
        check("abort3_pready", 32'(b3.pready), 32'h0);
        @(negedge clk);
        check("abort3_state", 32'(dut3.state_q), 32'(IDLE));
        xfer3(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("abort3_data", rd, 32'hAAAA5555);

        // Reset during ACCESS on the wait-state instance
        @(posedge clk); #1;
        b3.psel = 1; b3.penable = 0; b3.pwrite = 1; b3.paddr = 32'h40;
        b3.pwdata = 32'hFFFFFFFF; b3.pstrb = 4'hF; b3.pprot = 3'b000;
        @(posedge clk); #1 b3.penable = 1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; b3.psel = 0; b3.penable = 0;
        @(negedge clk);
        check("rst3_pready", 32'(b3.pready), 32'h0);
        check("rst3_pslverr", 32'(b3.pslverr), 32'h0);
        check("rst3_prdata", b3.prdata, 32'h0);
        check("rst3_state", 32'(dut3.state_q), 32'(IDLE));
        xfer3(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("rst3_data", rd, 32'hDEADBEEF);
        xfer0(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("rst3_dut0_data", rd, 32'hDE22BE44);
        idle0();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
